// File: rtl/hood_run_scheduler.sv
// Range-hood extraction fan scheduler: standby, three speed levels, timed level-3 exit and
// self-clean, plus the 1 s time base and the accumulated fan-on counter for the clean reminder.
module hood_run_scheduler #(
   parameter int unsigned TICK_DIV   = 100_000_000,
   parameter int unsigned L3_SEC     = 60,
   parameter int unsigned CLEAN_SEC  = 180,
   parameter int unsigned REMIND_SEC = 36000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        menu_pulse,
   input  logic [2:0]  lvl_pulse,
   input  logic        clean_pulse,
   output logic [2:0]  state,
   output logic [1:0]  fan_speed,
   output logic        countdown_active,
   output logic [7:0]  countdown_sec,
   output logic [19:0] work_sec,
   output logic        clean_due
);

   localparam int unsigned      DivW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DivW-1:0]  DivMax    = DivW'(TICK_DIV - 1);
   localparam logic [DivW-1:0]  DivOne    = DivW'(1);
   localparam logic [7:0]       L3Load    = 8'(L3_SEC);
   localparam logic [7:0]       CleanLoad = 8'(CLEAN_SEC);
   localparam logic [19:0]      WorkMax   = '1;
   localparam logic [19:0]      RemindThr = 20'(REMIND_SEC);

   typedef enum logic [2:0] {
      StStandby = 3'd0,
      StL1      = 3'd1,
      StL2      = 3'd2,
      StL3      = 3'd3,
      StExit    = 3'd4,
      StClean   = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            l3_used_q, l3_used_d;
   logic [19:0]     work_q, work_d;
   logic [1:0]      fan_q, fan_d;
   logic            active_q, active_d;

   logic            tick;
   logic            counting;
   logic            expire;
   logic            work_clr;
   logic            enter_l3;
   logic            lvl_valid;
   state_e          lvl_target;

   assign tick     = (div_q == DivMax);
   assign counting = (state_q == StL3) || (state_q == StExit) || (state_q == StClean);
   assign expire   = counting && tick && (cnt_q == 8'd1);

   // A blocked L3 request swallows the whole pulse, including any lower bits.
   assign lvl_valid  = (lvl_pulse != 3'b000) && !(lvl_pulse[2] && l3_used_q);
   assign lvl_target = lvl_pulse[2] ? StL3 : (lvl_pulse[1] ? StL2 : StL1);

   // State and timer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StStandby;
         div_q     <= '0;
         cnt_q     <= 8'd0;
         l3_used_q <= 1'b0;
         work_q    <= 20'd0;
         fan_q     <= 2'd0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         l3_used_q <= l3_used_d;
         work_q    <= work_d;
         fan_q     <= fan_d;
         active_q  <= active_d;
      end
   end

   // Next-state and countdown logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      l3_used_d = l3_used_q;
      work_clr  = 1'b0;
      enter_l3  = 1'b0;

      if (counting && tick && (cnt_q != 8'd0)) begin
         cnt_d = cnt_q - 8'd1;
      end

      if (!en) begin
         state_d   = StStandby;
         cnt_d     = 8'd0;
         l3_used_d = 1'b0;
      end else begin
         case (state_q)
            StStandby: begin
               if (clean_pulse) begin
                  state_d = StClean;
                  cnt_d   = CleanLoad;
               end else if (lvl_valid) begin
                  if (lvl_target == StL3) enter_l3 = 1'b1;
                  else                    state_d  = lvl_target;
               end
            end
            StL1, StL2: begin
               if (menu_pulse) begin
                  state_d = StStandby;
               end else if (lvl_valid) begin
                  if (lvl_target == StL3) enter_l3 = 1'b1;
                  else                    state_d  = lvl_target;
               end
            end
            StL3: begin
               if (menu_pulse) begin
                  state_d = StExit;
                  cnt_d   = L3Load;
               end else if (expire) begin
                  state_d = StL2;
               end
            end
            StExit: begin
               if (expire) state_d = StStandby;
            end
            StClean: begin
               if (menu_pulse) begin
                  state_d = StStandby;
                  cnt_d   = 8'd0;
               end else if (expire) begin
                  state_d  = StStandby;
                  work_clr = 1'b1;
               end
            end
            default: begin
               state_d = StStandby;
               cnt_d   = 8'd0;
            end
         endcase
      end

      if (enter_l3) begin
         state_d   = StL3;
         cnt_d     = L3Load;
         l3_used_d = 1'b1;
      end
   end

   // Time base restarts on every state change so each phase gets whole seconds.
   always_comb begin
      if ((state_d != state_q) || tick) div_d = '0;
      else                              div_d = div_q + DivOne;
   end

   always_comb begin
      work_d = work_q;
      if (work_clr) begin
         work_d = 20'd0;
      end else if (tick && (fan_q != 2'd0) && (work_q != WorkMax)) begin
         work_d = work_q + 20'd1;
      end
   end

   // Output decode, registered alongside the state
   always_comb begin
      fan_d    = 2'd0;
      active_d = 1'b0;
      case (state_d)
         StL1:    fan_d = 2'd1;
         StL2:    fan_d = 2'd2;
         StL3:    begin fan_d = 2'd3; active_d = 1'b1; end
         StExit:  begin fan_d = 2'd2; active_d = 1'b1; end
         StClean: active_d = 1'b1;
         default: fan_d = 2'd0;
      endcase
   end

   assign state            = state_q;
   assign fan_speed        = fan_q;
   assign countdown_active = active_q;
   assign countdown_sec    = cnt_q;
   assign work_sec         = work_q;
   assign clean_due        = (work_q >= RemindThr);

endmodule

// File: tb/tb_hood_run_scheduler.sv
// Self-checking bench for hood_run_scheduler: directed scenarios plus a randomized run
// compared against a behavioural model of the hood's run rules.
module tb_hood_run_scheduler;

   localparam int TD  = 4;
   localparam int L3S = 3;
   localparam int CS  = 5;
   localparam int RS  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        menu_pulse = 1'b0;
   logic [2:0]  lvl_pulse = 3'b000;
   logic        clean_pulse = 1'b0;
   logic [2:0]  state;
   logic [1:0]  fan_speed;
   logic        countdown_active;
   logic [7:0]  countdown_sec;
   logic [19:0] work_sec;
   logic        clean_due;

   int n_checks = 0;
   int n_fail = 0;

   // Model: current mode, seconds left, L3 lockout, fan-on seconds, cycles since mode entry.
   int m_state, m_cnt, m_work, m_age;
   bit m_l3;

   hood_run_scheduler #(
      .TICK_DIV   (TD),
      .L3_SEC     (L3S),
      .CLEAN_SEC  (CS),
      .REMIND_SEC (RS)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .en               (en),
      .menu_pulse       (menu_pulse),
      .lvl_pulse        (lvl_pulse),
      .clean_pulse      (clean_pulse),
      .state            (state),
      .fan_speed        (fan_speed),
      .countdown_active (countdown_active),
      .countdown_sec    (countdown_sec),
      .work_sec         (work_sec),
      .clean_due        (clean_due)
   );

   always #5 clk = ~clk;

   function automatic int fan_of(input int s);
      case (s)
         1: return 1;
         2: return 2;
         3: return 3;
         4: return 2;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_work = 0; m_age = 0; m_l3 = 0;
   endtask

   task automatic model_step(input bit m, input bit [2:0] l, input bit c, input bit e);
      int  nxt, ncnt, req;
      bit  tick, counting, expire, clr;
      tick     = (m_age % TD) == (TD - 1);
      counting = (m_state >= 3);
      expire   = counting && tick && (m_cnt == 1);
      nxt  = m_state;
      ncnt = (counting && tick && m_cnt > 0) ? m_cnt - 1 : m_cnt;
      clr  = 0;
      req  = (l >= 4) ? 3 : (l >= 2) ? 2 : (l >= 1) ? 1 : 0;
      if (req == 3 && m_l3) req = 0;
      if (!e) begin
         nxt = 0; ncnt = 0; m_l3 = 0;
      end else if (m_state == 0) begin
         if (c) begin nxt = 5; ncnt = CS; end
         else if (req != 0) nxt = req;
      end else if (m_state == 1 || m_state == 2) begin
         if (m) nxt = 0;
         else if (req != 0) nxt = req;
      end else if (m_state == 3) begin
         if (m) begin nxt = 4; ncnt = L3S; end
         else if (expire) nxt = 2;
      end else if (m_state == 4) begin
         if (expire) nxt = 0;
      end else begin
         if (m) begin nxt = 0; ncnt = 0; end
         else if (expire) begin nxt = 0; clr = 1; end
      end
      if (nxt == 3 && m_state != 3) begin ncnt = L3S; m_l3 = 1; end
      if (clr) m_work = 0;
      else if (tick && fan_of(m_state) != 0 && m_work < 20'hFFFFF) m_work++;
      m_age   = (nxt != m_state) ? 0 : m_age + 1;
      m_state = nxt;
      m_cnt   = ncnt;
   endtask

   task automatic drive(input bit m, input bit [2:0] l, input bit c, input bit e);
      menu_pulse = m; lvl_pulse = l; clean_pulse = c; en = e;
      @(posedge clk);
      model_step(m, l, c, e);
      #1;
      menu_pulse = 0; lvl_pulse = 3'b000; clean_pulse = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 3'b000, 0, 1);
   endtask

   task automatic do_reset();
      reset = 0; en = 1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 0; en = 1;
      #3;
      n_checks++;
      if ({state, fan_speed, countdown_active, countdown_sec, work_sec, clean_due} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got st=%0d fan=%0d act=%0b cnt=%0d work=%0d due=%0b want all 0",
                  state, fan_speed, countdown_active, countdown_sec, work_sec, clean_due);
      end
      do_reset();
   endtask

   task automatic test_l3_expiry();
      drive(0, 3'b100, 0, 1);
      n_checks++;
      if ({state, fan_speed, countdown_active, countdown_sec} !== {3'd3, 2'd3, 1'b1, 8'd3}) begin
         n_fail++;
         $display("FAIL l3_entry: got st=%0d fan=%0d act=%0b cnt=%0d want 3 3 1 3",
                  state, fan_speed, countdown_active, countdown_sec);
      end
      idle(11);
      n_checks++;
      if ({state, countdown_sec} !== {3'd3, 8'd1}) begin
         n_fail++;
         $display("FAIL l3_before_expiry: got st=%0d cnt=%0d want 3 1", state, countdown_sec);
      end
      idle(1);
      n_checks++;
      if ({state, fan_speed, countdown_active, countdown_sec} !== {3'd2, 2'd2, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL l3_expiry: got st=%0d fan=%0d act=%0b cnt=%0d want 2 2 0 0",
                  state, fan_speed, countdown_active, countdown_sec);
      end
      drive(0, 3'b100, 0, 1);
      n_checks++;
      if (state !== 3'd2) begin
         n_fail++;
         $display("FAIL l3_lockout: got st=%0d want 2", state);
      end
   endtask

   task automatic test_l3_menu();
      drive(0, 3'b000, 0, 0);
      drive(0, 3'b100, 0, 1);
      idle(5);
      drive(1, 3'b000, 0, 1);
      n_checks++;
      if ({state, fan_speed, countdown_sec} !== {3'd4, 2'd2, 8'd3}) begin
         n_fail++;
         $display("FAIL exit_entry: got st=%0d fan=%0d cnt=%0d want 4 2 3",
                  state, fan_speed, countdown_sec);
      end
      idle(11);
      n_checks++;
      if ({state, countdown_sec} !== {3'd4, 8'd1}) begin
         n_fail++;
         $display("FAIL exit_before_expiry: got st=%0d cnt=%0d want 4 1", state, countdown_sec);
      end
      idle(1);
      n_checks++;
      if ({state, fan_speed, countdown_active} !== {3'd0, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL exit_expiry: got st=%0d fan=%0d act=%0b want 0 0 0",
                  state, fan_speed, countdown_active);
      end
   endtask

   task automatic test_work_clean();
      do_reset();
      drive(0, 3'b010, 0, 1);
      idle(39);
      n_checks++;
      if ({work_sec, clean_due} !== {20'd9, 1'b0}) begin
         n_fail++;
         $display("FAIL work_9: got work=%0d due=%0b want 9 0", work_sec, clean_due);
      end
      idle(1);
      n_checks++;
      if ({work_sec, clean_due} !== {20'd10, 1'b1}) begin
         n_fail++;
         $display("FAIL work_10: got work=%0d due=%0b want 10 1", work_sec, clean_due);
      end
      drive(1, 3'b000, 0, 1);
      drive(0, 3'b000, 1, 1);
      n_checks++;
      if ({state, fan_speed, countdown_sec} !== {3'd5, 2'd0, 8'd5}) begin
         n_fail++;
         $display("FAIL clean_entry: got st=%0d fan=%0d cnt=%0d want 5 0 5",
                  state, fan_speed, countdown_sec);
      end
      idle(19);
      n_checks++;
      if ({state, countdown_sec, work_sec, clean_due} !== {3'd5, 8'd1, 20'd10, 1'b1}) begin
         n_fail++;
         $display("FAIL clean_before_end: got st=%0d cnt=%0d work=%0d due=%0b want 5 1 10 1",
                  state, countdown_sec, work_sec, clean_due);
      end
      idle(1);
      n_checks++;
      if ({state, countdown_sec, work_sec, clean_due} !== {3'd0, 8'd0, 20'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL clean_done: got st=%0d cnt=%0d work=%0d due=%0b want 0 0 0 0",
                  state, countdown_sec, work_sec, clean_due);
      end
   endtask

   task automatic test_clean_abort();
      drive(0, 3'b001, 0, 1);
      idle(8);
      drive(1, 3'b000, 0, 1);
      drive(0, 3'b000, 1, 1);
      idle(8);
      drive(1, 3'b000, 0, 1);
      n_checks++;
      if ({state, countdown_sec, work_sec} !== {3'd0, 8'd0, 20'd2}) begin
         n_fail++;
         $display("FAIL clean_abort: got st=%0d cnt=%0d work=%0d want 0 0 2",
                  state, countdown_sec, work_sec);
      end
   endtask

   task automatic test_priority();
      drive(0, 3'b011, 1, 1);
      n_checks++;
      if (state !== 3'd5) begin
         n_fail++;
         $display("FAIL clean_over_lvl: got st=%0d want 5", state);
      end
      drive(1, 3'b000, 0, 1);
      drive(0, 3'b001, 0, 1);
      drive(1, 3'b010, 0, 1);
      n_checks++;
      if (state !== 3'd0) begin
         n_fail++;
         $display("FAIL menu_over_lvl: got st=%0d want 0", state);
      end
   endtask

   task automatic test_en_drop();
      drive(0, 3'b000, 0, 0);
      drive(0, 3'b100, 0, 1);
      idle(5);
      drive(0, 3'b000, 0, 0);
      n_checks++;
      if ({state, countdown_sec, countdown_active} !== {3'd0, 8'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL en_drop: got st=%0d cnt=%0d act=%0b want 0 0 0",
                  state, countdown_sec, countdown_active);
      end
      drive(0, 3'b100, 0, 1);
      n_checks++;
      if (state !== 3'd3) begin
         n_fail++;
         $display("FAIL l3_after_en: got st=%0d want 3", state);
      end
      drive(1, 3'b000, 0, 1);
      idle(2);
      #2;
      reset = 0;
      #1;
      n_checks++;
      if ({state, fan_speed, countdown_active, countdown_sec, work_sec, clean_due} !== 35'd0) begin
         n_fail++;
         $display("FAIL async_reset: got st=%0d fan=%0d act=%0b cnt=%0d work=%0d due=%0b want 0",
                  state, fan_speed, countdown_active, countdown_sec, work_sec, clean_due);
      end
      @(posedge clk);
      #1;
      reset = 1;
      model_reset();
   endtask

   task automatic test_random();
      logic [34:0] exp_v, got_v;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(99) < 3, ($urandom_range(99) < 6) ? 3'($urandom_range(7)) : 3'b000,
               $urandom_range(99) < 3, $urandom_range(99) >= 1);
         exp_v = {3'(m_state), 2'(fan_of(m_state)), 1'(m_state >= 3), 8'(m_cnt), 20'(m_work),
                  1'(m_work >= RS)};
         got_v = {state, fan_speed, countdown_active, countdown_sec, work_sec, clean_due};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL random[%0d]: got st=%0d fan=%0d act=%0b cnt=%0d work=%0d due=%0b want st=%0d fan=%0d cnt=%0d work=%0d",
                     i, state, fan_speed, countdown_active, countdown_sec, work_sec, clean_due,
                     m_state, fan_of(m_state), m_cnt, m_work);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_l3_expiry();
      test_l3_menu();
      test_work_clean();
      test_clean_abort();
      test_priority();
      test_en_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
